counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl_pkg.sv | 37 +++
 rtl/counter_ctrl_key_filter.sv | 54 +++++
 rtl/counter_ctrl.sv | 144 ++++++++++++++
 tb/tb_counter_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the run/pause/clear counter controller:
// FSM state encoding, BCD digit width and small elaboration-time helpers.
package counter_ctrl_pkg;

  // Width of one BCD digit on the display bus.
  localparam int DIGIT_W = 4;

  // Width of the key-filter stability counter; covers DEB_CYCLES up to 15.
  localparam int DEB_CNT_W = 4;

  // FSM state codes. The codes are visible on the debug output, so they are
  // fixed explicitly rather than left to the tool.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // Divider register width: enough bits to hold 0..tick_div-1, never below 1.
  function automatic int div_width(input int tick_div);
    int w;
    w = $clog2(tick_div);
    return (w < 1) ? 1 : w;
  endfunction

  // Tens digit of a decimal count (terminal count split for the BCD compare).
  function automatic logic [DIGIT_W-1:0] bcd_tens(input int value);
    return DIGIT_W'((value / 10) % 10);
  endfunction

  // Ones digit of a decimal count.
  function automatic logic [DIGIT_W-1:0] bcd_ones(input int value);
    return DIGIT_W'(value % 10);
  endfunction

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_key_filter.sv
// Raw push-key conditioner: 2-FF synchroniser, consecutive-disagreement
// stability counter, and a one-clock press pulse on the filtered rising edge.
// Release is filtered the same way but produces no event.
module key_filter
  import counter_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  // Last count value before the filtered level flips.
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 filtered;
  logic                 filtered_d;
  logic [DEB_CNT_W-1:0] stab_cnt;

  // Synchronise the raw key and track how long it has disagreed with the
  // filtered level; flip the level once the disagreement has lasted
  // DEB_CYCLES consecutive edges. Any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      filtered   <= 1'b0;
      filtered_d <= 1'b0;
      stab_cnt   <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      filtered_d <= filtered;
      if (sync2 != filtered) begin
        if (stab_cnt == CNT_LAST) begin
          filtered <= ~filtered;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + DEB_CNT_W'(1);
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  // One clock wide: high only in the cycle right after the level rose.
  assign press = filtered & ~filtered_d;

endmodule : key_filter

// File: rtl/counter_ctrl.sv
// Run/pause/clear controller for the 0..MAX_COUNT BCD counter. Two filtered
// keys drive a three-state FSM (IDLE/RUN/PAUSE); while in RUN a divider
// produces one count step every TICK_DIV clocks. All outputs are registered.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int TICK_DIV   = 100,
  parameter int MAX_COUNT  = 19
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_run,
  input  logic               key_clr,
  output logic [DIGIT_W-1:0] cnt_ones,
  output logic [DIGIT_W-1:0] cnt_tens,
  output logic               running,
  output logic               wrap,
  output logic [1:0]         state
);

  localparam int                 DIV_W    = div_width(TICK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIGIT_W-1:0] MAX_ONES = bcd_ones(MAX_COUNT);
  localparam logic [DIGIT_W-1:0] MAX_TENS = bcd_tens(MAX_COUNT);

  logic run_press;
  logic clr_press;

  state_t             cur_state;
  state_t             nxt_state;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [DIGIT_W-1:0] ones_q;
  logic [DIGIT_W-1:0] ones_d;
  logic [DIGIT_W-1:0] tens_q;
  logic [DIGIT_W-1:0] tens_d;
  logic               wrap_q;
  logic               wrap_d;
  logic               running_q;

  key_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_run_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_run),
    .press (run_press)
  );

  key_filter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_clr_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (key_clr),
    .press (clr_press)
  );

  // State, divider, count and registered flags; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      div_q     <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      div_q     <= div_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      wrap_q    <= wrap_d;
      running_q <= (nxt_state == RUN);
    end
  end

  // Next-state, divider and BCD count. A run press in RUN pauses without
  // stepping; a clear press is applied last so it beats a run press or a
  // tick landing on the same edge, and it suppresses the wrap pulse.
  always_comb begin
    nxt_state = cur_state;
    div_d     = div_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    wrap_d    = 1'b0;

    unique case (cur_state)
      IDLE: begin
        if (run_press) begin
          nxt_state = RUN;
          div_d     = '0;
        end
      end
      RUN: begin
        if (run_press) begin
          nxt_state = PAUSE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if ((ones_q == MAX_ONES) && (tens_q == MAX_TENS)) begin
            ones_d = '0;
            tens_d = '0;
            wrap_d = 1'b1;
          end else if (ones_q == DIGIT_W'(9)) begin
            ones_d = '0;
            tens_d = tens_q + DIGIT_W'(1);
          end else begin
            ones_d = ones_q + DIGIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (run_press) begin
          nxt_state = RUN;
        end
      end
      default: begin
        // Unreachable code: recover to a known idle condition.
        nxt_state = IDLE;
        div_d     = '0;
        ones_d    = '0;
        tens_d    = '0;
      end
    endcase

    if (clr_press) begin
      nxt_state = IDLE;
      div_d     = '0;
      ones_d    = '0;
      tens_d    = '0;
      wrap_d    = 1'b0;
    end
  end

  assign cnt_ones = ones_q;
  assign cnt_tens = tens_q;
  assign wrap     = wrap_q;
  assign running  = running_q;
  assign state    = cur_state;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl at default parameters (DEB_CYCLES=3,
// TICK_DIV=100, MAX_COUNT=19). Inputs change 1 time unit after a rising
// edge and outputs are sampled at that same point.
module tb_counter_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_run;
  logic       key_clr;
  logic [3:0] cnt_ones;
  logic [3:0] cnt_tens;
  logic       running;
  logic       wrap;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  counter_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_run  (key_run),
    .key_clr  (key_clr),
    .cnt_ones (cnt_ones),
    .cnt_tens (cnt_tens),
    .running  (running),
    .wrap     (wrap),
    .state    (state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected display value for a decimal count, packed {tens, ones}.
  function automatic logic [31:0] bcd(input int k);
    return 32'(((k / 10) << 4) | (k % 10));
  endfunction

  function automatic logic [31:0] shown();
    return {24'd0, cnt_tens, cnt_ones};
  endfunction

  logic [9:0] bounce_pat = 10'b1011010110;

  initial begin
    rst_n   = 1'b0;
    key_run = 1'b0;
    key_clr = 1'b0;

    // Reset for two edges.
    step(2);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_count", shown(), bcd(0));
    check("rst_running", 32'(running), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);

    // Press latency: key high from just before edge 0, FSM acts at edge 5.
    rst_n   = 1'b1;
    key_run = 1'b1;
    step(5);
    check("lat_edge4_idle", 32'(state), 32'(S_IDLE));
    step(1);
    check("lat_edge5_run", 32'(state), 32'(S_RUN));
    check("lat_running", 32'(running), 32'd1);
    key_run = 1'b0;

    // Count 1..19 every 100 edges after entering RUN, then wrap.
    step(99);
    check("cnt_before_first", shown(), bcd(0));
    step(1);
    check("cnt_first", shown(), bcd(1));
    for (int k = 2; k <= 19; k++) begin
      step(100);
      check($sformatf("cnt_%0d", k), shown(), bcd(k));
    end
    step(100);
    check("wrap_count", shown(), bcd(0));
    check("wrap_pulse", 32'(wrap), 32'd1);
    step(1);
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    check("wrap_still_run", 32'(state), 32'(S_RUN));

    // Plain clear from RUN at count 3.
    step(299);
    check("pre_clr_count", shown(), bcd(3));
    key_clr = 1'b1;
    step(6);
    check("clr_state", 32'(state), 32'(S_IDLE));
    check("clr_count", shown(), bcd(0));
    check("clr_running", 32'(running), 32'd0);
    key_clr = 1'b0;
    step(8);

    // Pause at count 2 / divider 50, hold, resume: step 50 edges later.
    key_run = 1'b1;
    step(6);
    check("pr_run", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(245);
    key_run = 1'b1;
    step(6);
    check("pr_pause", 32'(state), 32'(S_PAUSE));
    check("pr_pause_count", shown(), bcd(2));
    check("pr_pause_running", 32'(running), 32'd0);
    key_run = 1'b0;
    step(300);
    check("pr_hold_state", 32'(state), 32'(S_PAUSE));
    check("pr_hold_count", shown(), bcd(2));
    key_run = 1'b1;
    step(6);
    check("pr_resume", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(49);
    check("pr_before_step", shown(), bcd(2));
    step(1);
    check("pr_step", shown(), bcd(3));

    // Run and clear on the same edge at count 7: clear wins.
    step(400);
    check("both_pre_count", shown(), bcd(7));
    key_run = 1'b1;
    key_clr = 1'b1;
    step(6);
    check("both_state", 32'(state), 32'(S_IDLE));
    check("both_count", shown(), bcd(0));
    check("both_running", 32'(running), 32'd0);
    key_run = 1'b0;
    key_clr = 1'b0;
    step(8);
    check("both_stay_idle", 32'(state), 32'(S_IDLE));

    // Clear landing on the wrapping tick: count 0, no wrap pulse.
    key_run = 1'b1;
    step(6);
    check("ct_run", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(1994);
    check("ct_pre_count", shown(), bcd(19));
    key_clr = 1'b1;
    step(6);
    check("ct_state", 32'(state), 32'(S_IDLE));
    check("ct_count", shown(), bcd(0));
    check("ct_wrap", 32'(wrap), 32'd0);
    key_clr = 1'b0;
    step(1);
    check("ct_wrap_next", 32'(wrap), 32'd0);
    step(8);

    // Reset mid-count at 13 with the run key held, then one fresh press.
    key_run = 1'b1;
    step(6);
    check("rm_run", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(1300);
    check("rm_pre_count", shown(), bcd(13));
    key_run = 1'b1;
    rst_n   = 1'b0;
    step(1);
    check("rm_state", 32'(state), 32'(S_IDLE));
    check("rm_count", shown(), bcd(0));
    check("rm_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    step(5);
    check("rm_edge4_idle", 32'(state), 32'(S_IDLE));
    step(1);
    check("rm_edge5_run", 32'(state), 32'(S_RUN));
    step(20);
    check("rm_single_press", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(8);
    key_clr = 1'b1;
    step(6);
    check("rm_clr_idle", 32'(state), 32'(S_IDLE));
    key_clr = 1'b0;
    step(8);

    // Bounce shorter than the filter window, then a clean hold.
    for (int i = 9; i >= 0; i--) begin
      key_run = bounce_pat[i];
      step(1);
    end
    step(6);
    check("bounce_no_event", 32'(state), 32'(S_IDLE));
    key_run = 1'b1;
    step(5);
    check("bounce_edge4_idle", 32'(state), 32'(S_IDLE));
    step(1);
    check("bounce_run", 32'(state), 32'(S_RUN));
    step(20);
    check("bounce_no_pause", 32'(state), 32'(S_RUN));
    key_run = 1'b0;
    step(10);
    check("bounce_release_run", 32'(state), 32'(S_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_ctrl
